audio_dac_serializer: RTL and testbench
=======================================

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 The block SHALL have parameter AUDIO_DATA_WIDTH, default 16, meaning the sample width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 128, meaning the per-channel FIFO depth in words; it is fixed at 128.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; reset reset, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port bit_clk_rising_edge, input, 1 bit: one-clk pulse on a BCLK rise.
REQ-006 The block SHALL have port bit_clk_falling_edge, input, 1 bit: one-clk pulse on a BCLK fall.
REQ-007 The block SHALL have port left_right_clk_rising_edge, input, 1 bit: one-clk pulse on a DACLRCK rise, which starts the left slot.
REQ-008 The block SHALL have port left_right_clk_falling_edge, input, 1 bit: one-clk pulse on a DACLRCK fall, which starts the right slot.
REQ-009 The block SHALL have port left_channel_data, input, AUDIO_DATA_WIDTH bits: left sample to push.
REQ-010 The block SHALL have port left_channel_data_en, input, 1 bit: push strobe for the left FIFO.
REQ-011 The block SHALL have port right_channel_data, input, AUDIO_DATA_WIDTH bits: right sample to push.
REQ-012 The block SHALL have port right_channel_data_en, input, 1 bit: push strobe for the right FIFO.
REQ-013 The block SHALL have port left_channel_fifo_write_space, output, 8 bits: free left FIFO entries, range 0..128.
REQ-014 The block SHALL have port right_channel_fifo_write_space, output, 8 bits: free right FIFO entries, range 0..128.
REQ-015 The block SHALL have port serial_audio_out_data, output, 1 bit: left-justified serial data to the codec (AUD_DACDAT).

Function
REQ-016 The block SHALL contain two independent 128-entry FIFOs, left and right, each with a 0..128 occupancy count; write_space SHALL equal 128 - count, registered, and updated the cycle after a push or pop.
REQ-017 A push with data_en=1 and count<128 SHALL store the data; a push with count==128 SHALL be dropped, leave the count unchanged, and corrupt nothing.
REQ-018 A push and a pop on the same FIFO in the same cycle SHALL leave the count unchanged; a push into an empty FIFO SHALL never be popped in the same cycle.
REQ-019 Read and write pointers SHALL be 7 bits and wrap 127->0 silently.
REQ-020 On left_right_clk_rising_edge with both FIFOs non-empty, the block SHALL pop one word from each FIFO, load left into the shift register, and hold right in right_hold.
REQ-021 On left_right_clk_rising_edge with either FIFO empty, the block SHALL pop neither FIFO and SHALL load zero into both the shift register and right_hold, so the channels never desynchronise.
REQ-022 On left_right_clk_falling_edge the block SHALL load right_hold into the shift register.
REQ-023 serial_audio_out_data SHALL be the shift register MSB, registered; the MSB appears 1 clk after the LR edge pulse.
REQ-024 On each bit_clk_falling_edge that is not coincident with an LR edge pulse, the shift register SHALL shift left by 1 with zero fill.
REQ-025 After AUDIO_DATA_WIDTH bits the output SHALL stay 0 until the next LR edge.
REQ-026 Priority when events coincide: LR edge load > bclk shift; bit_clk_rising_edge SHALL be ignored.
REQ-027 State machine: IDLE (no LR edge yet, output 0) -> LEFT on LR rise -> RIGHT on LR fall -> LEFT on LR rise.
REQ-028 An LR fall seen in IDLE SHALL be ignored, so the first frame always starts with left.
REQ-029 A repeated same-polarity LR edge SHALL reload per REQ-020 to REQ-022; no error is flagged.

Reset
REQ-030 On reset the block SHALL empty both FIFOs (pointers 0, count 0), set both write_space outputs to 8'h80, set the shift register and right_hold to 0, set serial_audio_out_data to 0, and set the state to IDLE.
REQ-031 Reset asserted mid-frame SHALL force the output to 0 on the next clk and discard all queued and in-flight samples; no pops SHALL occur while reset is high.
REQ-032 After reset deasserts, the block SHALL wait in IDLE for an LR rise before any pop.

Verification
REQ-033 Scenario: reset, then idle -> both write_space = 128 and serial out = 0 for 100 clks with no LR edges.
REQ-034 Scenario: push left 16'hA5F0 and right 16'h0F0F, then LR rise plus 16 bclk falls, then LR fall plus 16 bclk falls -> serial bits 1010010111110000 then 0000111100001111; write_space 127 -> 128 after the pop.
REQ-035 Scenario: push left only (3 words), then LR rise -> no pop, 32 zero bits out, left write_space stays 125.
REQ-036 Scenario: 130 left pushes with no pops -> left write_space = 0, words 129 and 130 dropped; later pops return the first 128 words in order.
REQ-037 Scenario: push and pop in the same cycle with count = 5 -> count stays 5, popped word is the oldest; pointer wrap exercised across 300 frames with a data compare.
REQ-038 Scenario: reset asserted after bit 7 of the left slot -> out = 0 next clk, write_space = 128, and the first LR fall after release produces no output.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// Left-justified DAC serializer: two 128-word sample FIFOs feeding a shift register
// that is reloaded on every DACLRCK edge and shifted out on BCLK falls.
module audio_dac_serializer #(
  parameter int AUDIO_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH       = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bit_clk_rising_edge,
  input  logic                        bit_clk_falling_edge,
  input  logic                        left_right_clk_rising_edge,
  input  logic                        left_right_clk_falling_edge,
  input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
  input  logic                        left_channel_data_en,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
  input  logic                        right_channel_data_en,
  output logic [7:0]                  left_channel_fifo_write_space,
  output logic [7:0]                  right_channel_fifo_write_space,
  output logic                        serial_audio_out_data
);

  localparam int         W     = AUDIO_DATA_WIDTH;
  localparam logic [7:0] DEPTH = 8'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t state;

  logic [W-1:0] left_mem  [FIFO_DEPTH];
  logic [W-1:0] right_mem [FIFO_DEPTH];
  logic [6:0]   l_wr_ptr, l_rd_ptr, r_wr_ptr, r_rd_ptr;
  logic [7:0]   l_count, r_count, l_count_next, r_count_next;
  logic         l_push, r_push, pop;
  logic [W-1:0] shift_reg, right_hold;

  // BCLK rises carry no meaning for a left-justified transmitter.
  logic unused_bclk_rise;
  assign unused_bclk_rise = bit_clk_rising_edge;

  // Pop only when both channels have data so left and right stay paired;
  // counts are the registered values, so a same-cycle push into empty is never popped.
  assign pop    = left_right_clk_rising_edge && (l_count != 8'd0) && (r_count != 8'd0);
  assign l_push = left_channel_data_en  && (l_count != DEPTH);
  assign r_push = right_channel_data_en && (r_count != DEPTH);

  always_comb begin
    l_count_next = l_count;
    r_count_next = r_count;
    if (l_push && !pop)      l_count_next = l_count + 8'd1;
    else if (!l_push && pop) l_count_next = l_count - 8'd1;
    if (r_push && !pop)      r_count_next = r_count + 8'd1;
    else if (!r_push && pop) r_count_next = r_count - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (l_push) left_mem[l_wr_ptr]  <= left_channel_data;
    if (r_push) right_mem[r_wr_ptr] <= right_channel_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_wr_ptr                       <= '0;
      l_rd_ptr                       <= '0;
      r_wr_ptr                       <= '0;
      r_rd_ptr                       <= '0;
      l_count                        <= '0;
      r_count                        <= '0;
      left_channel_fifo_write_space  <= 8'h80;
      right_channel_fifo_write_space <= 8'h80;
    end else begin
      if (l_push) l_wr_ptr <= l_wr_ptr + 7'd1;
      if (r_push) r_wr_ptr <= r_wr_ptr + 7'd1;
      if (pop) begin
        l_rd_ptr <= l_rd_ptr + 7'd1;
        r_rd_ptr <= r_rd_ptr + 7'd1;
      end
      l_count                        <= l_count_next;
      r_count                        <= r_count_next;
      left_channel_fifo_write_space  <= DEPTH - l_count_next;
      right_channel_fifo_write_space <= DEPTH - r_count_next;
    end
  end

  // The output bit is registered alongside the shift register from the same
  // next value, so the MSB is visible one clk after the LR pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      shift_reg             <= '0;
      right_hold            <= '0;
      serial_audio_out_data <= 1'b0;
    end else if (left_right_clk_rising_edge) begin
      state                 <= LEFT;
      shift_reg             <= pop ? left_mem[l_rd_ptr] : '0;
      right_hold            <= pop ? right_mem[r_rd_ptr] : '0;
      serial_audio_out_data <= pop ? left_mem[l_rd_ptr][W-1] : 1'b0;
    end else if (left_right_clk_falling_edge && state != IDLE) begin
      state                 <= RIGHT;
      shift_reg             <= right_hold;
      serial_audio_out_data <= right_hold[W-1];
    end else if (bit_clk_falling_edge) begin
      shift_reg             <= {shift_reg[W-2:0], 1'b0};
      serial_audio_out_data <= shift_reg[W-2];
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: queue model of both FIFOs, bit-by-bit
// check of every slot, reset and boundary scenarios.
`timescale 1ns/1ps
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_clk_rising_edge, bit_clk_falling_edge;
  logic        left_right_clk_rising_edge, left_right_clk_falling_edge;
  logic [15:0] left_channel_data, right_channel_data;
  logic        left_channel_data_en, right_channel_data_en;
  logic [7:0]  left_channel_fifo_write_space, right_channel_fifo_write_space;
  logic        serial_audio_out_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] ql[$];
  logic [15:0] qr[$];

  audio_dac_serializer #(.AUDIO_DATA_WIDTH(16), .FIFO_DEPTH(128)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .bit_clk_rising_edge            (bit_clk_rising_edge),
    .bit_clk_falling_edge           (bit_clk_falling_edge),
    .left_right_clk_rising_edge     (left_right_clk_rising_edge),
    .left_right_clk_falling_edge    (left_right_clk_falling_edge),
    .left_channel_data              (left_channel_data),
    .left_channel_data_en           (left_channel_data_en),
    .right_channel_data             (right_channel_data),
    .right_channel_data_en          (right_channel_data_en),
    .left_channel_fifo_write_space  (left_channel_fifo_write_space),
    .right_channel_fifo_write_space (right_channel_fifo_write_space),
    .serial_audio_out_data          (serial_audio_out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_space();
    chk("left_space",  {24'd0, left_channel_fifo_write_space},  128 - ql.size());
    chk("right_space", {24'd0, right_channel_fifo_write_space}, 128 - qr.size());
  endtask

  // Push into the FIFOs; the model drops pushes into a full queue.
  task automatic push(input bit do_l, input bit do_r, input logic [15:0] dl, input logic [15:0] dr);
    left_channel_data     = dl;
    right_channel_data    = dr;
    left_channel_data_en  = do_l;
    right_channel_data_en = do_r;
    tick();
    left_channel_data_en  = 1'b0;
    right_channel_data_en = 1'b0;
    if (do_l && ql.size() < 128) ql.push_back(dl);
    if (do_r && qr.size() < 128) qr.push_back(dr);
  endtask

  task automatic pulse_bf();
    bit_clk_falling_edge = 1'b1;
    tick();
    bit_clk_falling_edge = 1'b0;
  endtask

  task automatic pulse_br();
    bit_clk_rising_edge = 1'b1;
    tick();
    bit_clk_rising_edge = 1'b0;
  endtask

  // Starts just after the slot load: MSB first, BCLK rises ignored, zero after 16 bits.
  task automatic check_slot(input string tag, input logic [15:0] exp);
    for (int b = 15; b >= 0; b--) begin
      chk(tag, {31'd0, serial_audio_out_data}, {31'd0, exp[b]});
      pulse_br();
      chk({tag, "_after_rise"}, {31'd0, serial_audio_out_data}, {31'd0, exp[b]});
      pulse_bf();
    end
    chk({tag, "_tail"}, {31'd0, serial_audio_out_data}, 32'd0);
    pulse_bf();
    chk({tag, "_tail2"}, {31'd0, serial_audio_out_data}, 32'd0);
  endtask

  // One full frame; optional push and BCLK fall coincident with the LR rise.
  task automatic lr_frame(input bit do_push, input bit with_bf,
                          input logic [15:0] dl, input logic [15:0] dr);
    logic [15:0] el, er;
    bit ok_l, ok_r, do_pop;
    ok_l   = ql.size() < 128;
    ok_r   = qr.size() < 128;
    do_pop = ql.size() > 0 && qr.size() > 0;
    el = 16'd0;
    er = 16'd0;
    if (do_pop) begin
      el = ql.pop_front();
      er = qr.pop_front();
    end
    if (do_push && ok_l) ql.push_back(dl);
    if (do_push && ok_r) qr.push_back(dr);
    left_channel_data           = dl;
    right_channel_data          = dr;
    left_channel_data_en        = do_push;
    right_channel_data_en       = do_push;
    left_right_clk_rising_edge  = 1'b1;
    bit_clk_falling_edge        = with_bf;
    tick();
    left_channel_data_en        = 1'b0;
    right_channel_data_en       = 1'b0;
    left_right_clk_rising_edge  = 1'b0;
    bit_clk_falling_edge        = 1'b0;
    chk_space();
    check_slot("left_slot", el);
    left_right_clk_falling_edge = 1'b1;
    tick();
    left_right_clk_falling_edge = 1'b0;
    check_slot("right_slot", er);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    ql.delete();
    qr.delete();
    reset = 1'b0;
  endtask

  initial begin
    bit_clk_rising_edge         = 1'b0;
    bit_clk_falling_edge        = 1'b0;
    left_right_clk_rising_edge  = 1'b0;
    left_right_clk_falling_edge = 1'b0;
    left_channel_data           = '0;
    right_channel_data          = '0;
    left_channel_data_en        = 1'b0;
    right_channel_data_en       = 1'b0;
    reset                       = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, then 100 idle clocks.
    chk("reset_left_space",  {24'd0, left_channel_fifo_write_space},  32'h80);
    chk("reset_right_space", {24'd0, right_channel_fifo_write_space}, 32'h80);
    chk("reset_out", {31'd0, serial_audio_out_data}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_out", {31'd0, serial_audio_out_data}, 32'd0);
    end
    chk_space();

    // Single known frame.
    push(1'b1, 1'b1, 16'hA5F0, 16'h0F0F);
    chk("push_left_space",  {24'd0, left_channel_fifo_write_space},  32'd127);
    chk("push_right_space", {24'd0, right_channel_fifo_write_space}, 32'd127);
    lr_frame(1'b0, 1'b0, 16'h0, 16'h0);
    chk("pop_left_space", {24'd0, left_channel_fifo_write_space}, 32'd128);

    // Left only: no pop, zero frame, left space stays 125.
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 16'h8001 + 16'(i), 16'h0);
    lr_frame(1'b0, 1'b0, 16'h0, 16'h0);
    chk("left_only_space", {24'd0, left_channel_fifo_write_space}, 32'd125);
    do_reset();
    chk_space();

    // Overflow: 130 left pushes, last two dropped; pop 128 in order.
    for (int i = 0; i < 130; i++) push(1'b1, 1'b0, 16'h1000 + 16'(i), 16'h0);
    chk("full_left_space", {24'd0, left_channel_fifo_write_space}, 32'd0);
    for (int i = 0; i < 128; i++) push(1'b0, 1'b1, 16'h0, 16'h2000 + 16'(i * 3));
    for (int i = 0; i < 128; i++) lr_frame(1'b0, 1'b0, 16'h0, 16'h0);
    chk_space();
    lr_frame(1'b0, 1'b0, 16'h0, 16'h0);

    // Count 5 with push and pop together, then pointer wrap over 300 frames.
    for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 16'h5A00 + 16'(i), 16'hC300 + 16'(i));
    lr_frame(1'b1, 1'b0, 16'h7E7E, 16'h8181);
    chk("same_cycle_space", {24'd0, left_channel_fifo_write_space}, 32'd123);
    for (int i = 0; i < 300; i++)
      lr_frame(1'b1, i[0], 16'(i * 16'h9E37) ^ 16'h8421, 16'(i * 16'h3B5D) ^ 16'h4C1F);
    chk("wrap_space", {24'd0, right_channel_fifo_write_space}, 32'd123);

    // Reset mid-slot, then a stray LR fall must not start a frame.
    do_reset();
    push(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    left_right_clk_rising_edge = 1'b1;
    tick();
    left_right_clk_rising_edge = 1'b0;
    void'(ql.pop_front());
    void'(qr.pop_front());
    for (int i = 0; i < 7; i++) pulse_bf();
    chk("midframe_out", {31'd0, serial_audio_out_data}, 32'd1);
    do_reset();
    chk("rst_out", {31'd0, serial_audio_out_data}, 32'd0);
    chk_space();
    left_right_clk_falling_edge = 1'b1;
    tick();
    left_right_clk_falling_edge = 1'b0;
    check_slot("idle_fall", 16'h0000);
    chk_space();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
